// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and sync FSM state type.
// The sync generator uses the same constants, so both ends agree on the timing.
package vga_timing_pkg;

   localparam int H_TOTAL    = 800;
   localparam int V_TOTAL    = 525;
   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int H_SYNC     = 96;
   localparam int V_SYNC     = 2;
   localparam int H_EDGE_POS = 657;
   localparam int V_EDGE_POS = 491;
   localparam int LOCK_LINES = 4;
   localparam int CNT_W      = 11;
   localparam int POS_W      = 10;

   typedef enum logic [1:0] {
      SEARCH,
      ACQUIRE,
      LOCKED
   } sync_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync line and flags its rising edge one cycle after the input rises.
module sync_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_sync,
   output logic o_rise
);

   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= i_sync;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers hpos/vpos, line period, lines per frame and timing lock from hsync/vsync.
// Optional SYNC_STATS_EN adds a saturating lock-loss counter output.
//
// state   | meaning
// SEARCH  | no timing reference; waiting for an hsync rise
// ACQUIRE | collecting consecutive equal line periods
// LOCKED  | line period stable; locked=1
module vga_sync_decoder
   import vga_timing_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [POS_W-1:0] hpos,
   output logic [POS_W-1:0] vpos,
   output logic             active,
   output logic             locked,
   output logic             new_frame,
   output logic [CNT_W-1:0] line_period,
   output logic [POS_W-1:0] frame_lines
`ifdef SYNC_STATS_EN
   ,
   output logic [15:0]      lock_loss_cnt
`endif
);

   localparam int MATCH_W = $clog2(LOCK_LINES);
   localparam logic [POS_W-1:0]   H_LAST     = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0]   V_LAST     = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0]   H_LOAD     = POS_W'(H_EDGE_POS);
   localparam logic [POS_W-1:0]   V_LOAD     = POS_W'(V_EDGE_POS);
   localparam logic [POS_W-1:0]   H_ACT      = POS_W'(H_ACTIVE);
   localparam logic [POS_W-1:0]   V_ACT      = POS_W'(V_ACTIVE);
   // The reference period is itself the first equal period, so lock needs LOCK_LINES-1 repeats.
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_LINES - 2);

   logic w_h_rise;
   logic w_v_rise;
   logic w_h_wrap;
   logic w_timeout;
   logic w_period_eq;

   logic [POS_W-1:0]   r_hpos;
   logic [POS_W-1:0]   r_vpos;
   logic [CNT_W-1:0]   r_period_cnt;
   logic [CNT_W-1:0]   r_line_period;
   logic [CNT_W-1:0]   r_ref;
   logic [MATCH_W-1:0] r_match;
   logic [POS_W-1:0]   r_line_cnt;
   logic [POS_W-1:0]   r_frame_lines;
   logic               r_new_frame;
   sync_state_t        r_state;
   sync_state_t        w_next;

   sync_edge_detect u_hsync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sync (hsync_in),
      .o_rise (w_h_rise)
   );

   sync_edge_detect u_vsync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sync (vsync_in),
      .o_rise (w_v_rise)
   );

   assign w_h_wrap    = (r_hpos == H_LAST) && !w_h_rise;
   assign w_timeout   = &r_period_cnt;
   assign w_period_eq = (r_period_cnt == r_ref);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hpos        <= '0;
         r_vpos        <= '0;
         r_period_cnt  <= '0;
         r_line_period <= '0;
         r_line_cnt    <= '0;
         r_frame_lines <= '0;
         r_new_frame   <= 1'b0;
      end else begin
         r_new_frame <= w_v_rise;

         if (w_h_rise)      r_hpos <= H_LOAD;
         else if (w_h_wrap) r_hpos <= '0;
         else               r_hpos <= r_hpos + 1'b1;

         if (w_v_rise)      r_vpos <= V_LOAD;
         else if (w_h_wrap) r_vpos <= (r_vpos == V_LAST) ? '0 : r_vpos + 1'b1;

         if (w_h_rise) begin
            r_period_cnt  <= CNT_W'(1);
            r_line_period <= r_period_cnt;
         end else if (!w_timeout) begin
            r_period_cnt  <= r_period_cnt + 1'b1;
         end

         // An hsync rise coincident with the vsync rise opens the new frame's count.
         if (w_v_rise) begin
            r_frame_lines <= r_line_cnt;
            r_line_cnt    <= {{(POS_W-1){1'b0}}, w_h_rise};
         end else if (w_h_rise && !(&r_line_cnt)) begin
            r_line_cnt    <= r_line_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SEARCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = SEARCH;
      end else if (w_h_rise) begin
         case (r_state)
            SEARCH:  w_next = ACQUIRE;
            ACQUIRE: if (w_period_eq && r_match == MATCH_LOCK) w_next = LOCKED;
            LOCKED:  if (!w_period_eq) w_next = SEARCH;
            default: w_next = SEARCH;
         endcase
      end
   end

   always_comb begin
      locked = (r_state == LOCKED);
      active = locked && (r_hpos < H_ACT) && (r_vpos < V_ACT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref   <= '0;
         r_match <= '0;
      end else if (w_h_rise && !w_timeout) begin
         case (r_state)
            SEARCH: begin
               r_ref   <= '0;
               r_match <= '0;
            end
            ACQUIRE: begin
               if (w_period_eq) begin
                  r_match <= r_match + 1'b1;
               end else begin
                  r_ref   <= r_period_cnt;
                  r_match <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SYNC_STATS_EN
   logic [15:0] r_loss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_loss_cnt <= '0;
      else if (r_state == LOCKED && w_next == SEARCH && r_loss_cnt != 16'hFFFF)
         r_loss_cnt <= r_loss_cnt + 16'd1;
   end

   assign lock_loss_cnt = r_loss_cnt;
`endif

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign new_frame   = r_new_frame;
   assign line_period = r_line_period;
   assign frame_lines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: timing-rule model checked every cycle plus literal spot checks.
module tb_vga_sync_decoder;
   import vga_timing_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             hsync_in = 1'b0;
   logic             vsync_in = 1'b0;
   logic [9:0]       hpos, vpos, frame_lines;
   logic             active, locked, new_frame;
   logic [CNT_W-1:0] line_period;
`ifdef SYNC_STATS_EN
   logic [15:0]      lock_loss_cnt;
`endif

   always #5 clk = ~clk;

   vga_sync_decoder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hpos        (hpos),
      .vpos        (vpos),
      .active      (active),
      .locked      (locked),
      .new_frame   (new_frame),
      .line_period (line_period),
      .frame_lines (frame_lines)
`ifdef SYNC_STATS_EN
      ,
      .lock_loss_cnt (lock_loss_cnt)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;
   int nf_pulses = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Model: spec rules in terms of edge times and measured periods.
   int  m_c, m_last_rise, m_hpos, m_vpos, m_lp, m_fl, m_hcnt, m_loss, m_lock_period;
   bit  m_hp1, m_hp2, m_vp1, m_vp2, m_nf, m_armed, m_locked;
   int  m_seq[$];

   task automatic model_reset();
      m_c = 0; m_last_rise = 1; m_hpos = 0; m_vpos = 0; m_lp = 0; m_fl = 0;
      m_hcnt = 0; m_loss = 0; m_lock_period = 0;
      m_hp1 = 0; m_hp2 = 0; m_vp1 = 0; m_vp2 = 0; m_nf = 0; m_armed = 0; m_locked = 0;
      m_seq.delete();
   endtask

   task automatic model_step(input bit h, input bit v);
      bit hr, vr, was, run_ok;
      int cnt_before, old, n;
      m_c++;
      hr = m_hp1 && !m_hp2;
      vr = m_vp1 && !m_vp2;
      m_hp2 = m_hp1; m_hp1 = h;
      m_vp2 = m_vp1; m_vp1 = v;
      cnt_before = (m_c - 1) - m_last_rise + 1;
      if (cnt_before > 2047) cnt_before = 2047;
      if (cnt_before < 0) cnt_before = 0;
      was = m_locked;
      if (cnt_before == 2047) begin
         m_locked = 0; m_armed = 0; m_seq.delete();
      end else if (hr) begin
         if (m_locked) begin
            if (cnt_before != m_lock_period) begin
               m_locked = 0; m_armed = 0; m_seq.delete();
            end
         end else if (!m_armed) begin
            m_armed = 1; m_seq.delete();
         end else begin
            m_seq.push_back(cnt_before);
            n = m_seq.size();
            run_ok = (n >= LOCK_LINES);
            for (int i = 1; i < LOCK_LINES && run_ok; i++)
               if (m_seq[n-1-i] != cnt_before) run_ok = 0;
            if (run_ok) begin
               m_locked = 1; m_lock_period = cnt_before;
            end
         end
      end
      if (was && !m_locked && m_loss < 65535) m_loss++;
      if (hr) begin
         m_last_rise = m_c;
         m_lp = cnt_before;
      end
      old = m_hpos;
      m_hpos = hr ? H_EDGE_POS : (old + 1) % H_TOTAL;
      if (vr) m_vpos = V_EDGE_POS;
      else if (!hr && old == H_TOTAL - 1) m_vpos = (m_vpos + 1) % V_TOTAL;
      if (vr) begin
         m_fl = m_hcnt;
         m_hcnt = hr ? 1 : 0;
      end else if (hr && m_hcnt < 1023) begin
         m_hcnt++;
      end
      m_nf = vr;
   endtask

   task automatic check_cycle();
      bit ok;
      bit e_act;
      e_act = m_locked && (m_hpos < H_ACTIVE) && (m_vpos < V_ACTIVE);
      ok = (int'(hpos) == m_hpos) && (int'(vpos) == m_vpos) && (locked == m_locked) &&
           (active == e_act) && (new_frame == m_nf) && (int'(line_period) == m_lp) &&
           (int'(frame_lines) == m_fl);
`ifdef SYNC_STATS_EN
      ok = ok && (int'(lock_loss_cnt) == m_loss);
`endif
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL cycle %0d: got h=%0d v=%0d lk=%0d act=%0d nf=%0d lp=%0d fl=%0d; expected h=%0d v=%0d lk=%0d act=%0d nf=%0d lp=%0d fl=%0d",
                    m_c, hpos, vpos, locked, active, new_frame, line_period, frame_lines,
                    m_hpos, m_vpos, m_locked, e_act, m_nf, m_lp, m_fl);
   endtask

   task automatic tick(input bit h, input bit v);
      hsync_in = h;
      vsync_in = v;
      @(posedge clk);
      model_step(h, v);
      @(negedge clk);
      check_cycle();
      if (new_frame) nf_pulses++;
   endtask

   int g_len = 800, g_hw = H_SYNC, g_pos = 0;
   bit g_vs = 0;

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         tick(g_pos < g_hw, g_vs);
         g_pos = (g_pos + 1) % g_len;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hpos"}, hpos, 0);
      chk({tag, "_vpos"}, vpos, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_active"}, active, 0);
      chk({tag, "_new_frame"}, new_frame, 0);
      chk({tag, "_line_period"}, line_period, 0);
      chk({tag, "_frame_lines"}, frame_lines, 0);
`ifdef SYNC_STATS_EN
      chk({tag, "_lock_loss_cnt"}, lock_loss_cnt, 0);
`endif
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      model_reset();
      repeat (3) tick(0, 0);

      // Lock on 800-clock lines: locked one cycle after the 5th rise.
      run(4 * 800);
      run(1);
      chk("t1_prelock", locked, 0);
      run(1);
      chk("t1_locked", locked, 1);
      chk("t1_line_period", line_period, 800);
      run(798);

      // One short line drops lock at the following rise, then relock after 5 clean rises.
      g_len = 799; run(799); g_len = 800;
      run(1);
      chk("t2_still_locked", locked, 1);
      run(1);
      chk("t2_lock_lost", locked, 0);
      chk("t2_line_period", line_period, 799);
`ifdef SYNC_STATS_EN
      chk("t2_lock_loss_cnt", lock_loss_cnt, 1);
`endif
      run(798);
      run(4 * 800);
      run(1);
      chk("t2_relock_pre", locked, 0);
      run(1);
      chk("t2_relock", locked, 1);

      // hsync stuck low: counter saturates 2046 clocks after the last load, lock drops next cycle.
      repeat (2046) tick(0, 0);
      chk("t3_before_timeout", locked, 1);
      tick(0, 0);
      chk("t3_timeout", locked, 0);
      repeat (60) tick(0, 0);
      chk("t3_line_period_kept", line_period, 800);

      // Relock, then active boundary at hpos 639/640.
      g_pos = 0;
      run(7 * 800);
      chk("t5_locked", locked, 1);
      run(784);
      chk("t5_hpos639", hpos, 639);
      chk("t5_active_in", active, 1);
      run(1);
      chk("t5_hpos640", hpos, 640);
      chk("t5_active_out", active, 0);
      run(15);

      // Short 20-clock lines; 525-line frame with 2-line vsync.
      g_len = 20; g_hw = 4;
      g_vs = 1; run(40); g_vs = 0;
      nf_pulses = 0;
      run(523 * 20);
      g_vs = 1;
      run(1);
      run(1);
      chk("t4_frame_lines", frame_lines, 525);
      chk("t4_vpos_load", vpos, V_EDGE_POS);
      chk("t4_new_frame", new_frame, 1);
      run(1);
      chk("t4_new_frame_end", new_frame, 0);
      chk("t4_pulse_count", nf_pulses, 1);
      run(37);
      g_vs = 0;

      // Asynchronous reset mid-line while locked.
      run(60);
      chk("t6_locked", locked, 1);
      run(7);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("t6_async");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run(13);
      run(4 * 20);
      run(1);
      chk("t6_relock_pre", locked, 0);
      run(1);
      chk("t6_relock", locked, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
